// File: rtl/alu_multiciclo_nbits.sv
// Multicycle N-bit ALU with iterative multiply/divide, a HI/LO register pair and zero/overflow flags.
// The divider is built only when ALU_MULTICICLO_DIV_EN is defined; otherwise DIVU/DIV act as invalid codes that raise overflow.
module alu_multiciclo_nbits #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   operacion_i,
  input  logic         inicio_i,
  output logic         ocupado_o,
  output logic         listo_o,
  output logic [N-1:0] salida_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o,
  output logic         zeroflag_o,
  output logic         overflow_o
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  work_hi_reg, work_lo_reg, opnd_reg;
  logic          neg_reg;
`ifdef ALU_MULTICICLO_DIV_EN
  logic [N-1:0]  a_reg, b_reg;
  logic          is_div_reg, is_sdiv_reg, neg_r_reg;
`endif

  // Single-cycle operations are computed straight from the inputs at the accepting edge.
  logic [SW-1:0] sh_amt;
  logic [N-1:0]  add_res, sub_res, alu_res;
  logic          alu_ovf, alu_valid, alu_zero;

  assign sh_amt  = b_i[SW-1:0];
  assign add_res = a_i + b_i;
  assign sub_res = a_i - b_i;

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_valid = 1'b1;
    case (operacion_i)
      OP_AND: alu_res = a_i & b_i;
      OP_OR:  alu_res = a_i | b_i;
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (a_i[N-1] == b_i[N-1]) && (add_res[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (a_i[N-1] != b_i[N-1]) && (sub_res[N-1] != a_i[N-1]);
      end
      OP_SLT: alu_res = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLL: alu_res = a_i << sh_amt;
      OP_SRL: alu_res = a_i >> sh_amt;
      OP_SRA: alu_res = N'($signed(a_i) >>> sh_amt);
`ifndef ALU_MULTICICLO_DIV_EN
      OP_DIVU, OP_DIV: begin
        alu_valid = 1'b0;
        alu_ovf   = 1'b1;
      end
`endif
      default: alu_valid = 1'b0;
    endcase
  end

  assign alu_zero = alu_valid && (alu_res == '0);

  logic         start_long, start_div, signed_op;
  logic [N-1:0] mag_a, mag_b;

  always_comb begin
    start_long = (operacion_i == OP_MULTU) || (operacion_i == OP_MULT);
    start_div  = 1'b0;
`ifdef ALU_MULTICICLO_DIV_EN
    start_div  = (operacion_i == OP_DIVU) || (operacion_i == OP_DIV);
    start_long = start_long || start_div;
`endif
  end

  assign signed_op = (operacion_i == OP_MULT) || (operacion_i == OP_DIV);
  assign mag_a     = (signed_op && a_i[N-1]) ? -a_i : a_i;
  assign mag_b     = (signed_op && b_i[N-1]) ? -b_i : b_i;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  logic [N:0]   msum;
  logic [N-1:0] step_hi, step_lo;

  assign msum = {1'b0, work_hi_reg} + {1'b0, (work_lo_reg[0] ? opnd_reg : {N{1'b0}})};

`ifdef ALU_MULTICICLO_DIV_EN
  logic [N:0] shifted, ddiff;
  assign shifted = {work_hi_reg, work_lo_reg[N-1]};
  assign ddiff   = shifted - {1'b0, opnd_reg};
`endif

  always_comb begin
    step_hi = msum[N:1];
    step_lo = {msum[0], work_lo_reg[N-1:1]};
`ifdef ALU_MULTICICLO_DIV_EN
    if (is_div_reg) begin
      if (!ddiff[N]) begin
        step_hi = ddiff[N-1:0];
        step_lo = {work_lo_reg[N-2:0], 1'b1};
      end else begin
        step_hi = shifted[N-1:0];
        step_lo = {work_lo_reg[N-2:0], 1'b0};
      end
    end
`endif
  end

  // Sign correction and divide special cases, applied on the last iteration.
  logic [2*N-1:0] prod_raw, prod;
  logic [N-1:0]   fin_hi, fin_lo;
  logic           fin_ovf;

  assign prod_raw = {step_hi, step_lo};
  assign prod     = neg_reg ? -prod_raw : prod_raw;

  always_comb begin
    fin_hi  = prod[2*N-1:N];
    fin_lo  = prod[N-1:0];
    fin_ovf = 1'b0;
`ifdef ALU_MULTICICLO_DIV_EN
    if (is_div_reg) begin
      fin_lo = neg_reg   ? -step_lo : step_lo;
      fin_hi = neg_r_reg ? -step_hi : step_hi;
      if (b_reg == '0) begin
        fin_lo  = '1;
        fin_hi  = a_reg;
        fin_ovf = 1'b1;
      end else if (is_sdiv_reg && (a_reg == {1'b1, {(N-1){1'b0}}}) && (b_reg == '1)) begin
        fin_lo  = a_reg;
        fin_hi  = '0;
        fin_ovf = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      opnd_reg    <= '0;
      neg_reg     <= 1'b0;
`ifdef ALU_MULTICICLO_DIV_EN
      a_reg       <= '0;
      b_reg       <= '0;
      is_div_reg  <= 1'b0;
      is_sdiv_reg <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
      ocupado_o   <= 1'b0;
      listo_o     <= 1'b0;
      salida_o    <= '0;
      hi_o        <= '0;
      lo_o        <= '0;
      zeroflag_o  <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          listo_o <= 1'b0;
          if (inicio_i) begin
            ocupado_o <= 1'b1;
            if (start_long) begin
              state_reg   <= CALC;
              cnt_reg     <= CW'(N);
              work_hi_reg <= '0;
              work_lo_reg <= start_div ? mag_a : mag_b;
              opnd_reg    <= start_div ? mag_b : mag_a;
              neg_reg     <= signed_op && (a_i[N-1] ^ b_i[N-1]);
`ifdef ALU_MULTICICLO_DIV_EN
              a_reg       <= a_i;
              b_reg       <= b_i;
              is_div_reg  <= start_div;
              is_sdiv_reg <= (operacion_i == OP_DIV);
              neg_r_reg   <= signed_op && a_i[N-1];
`endif
            end else begin
              state_reg  <= DONE;
              listo_o    <= 1'b1;
              salida_o   <= alu_res;
              zeroflag_o <= alu_zero;
              overflow_o <= alu_ovf;
            end
          end
        end
        CALC: begin
          work_hi_reg <= step_hi;
          work_lo_reg <= step_lo;
          cnt_reg     <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg  <= DONE;
            listo_o    <= 1'b1;
            hi_o       <= fin_hi;
            lo_o       <= fin_lo;
            salida_o   <= fin_lo;
            zeroflag_o <= (fin_lo == '0);
            overflow_o <= fin_ovf;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          listo_o   <= 1'b0;
          ocupado_o <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo_nbits.sv
// Scoreboard bench for alu_multiciclo_nbits at N=8: stimulus pushes expected results, a monitor checks each listo_o pulse.
// Divide vectors follow ALU_MULTICICLO_DIV_EN as seen by this compilation.
module tb_alu_multiciclo_nbits;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a_in, b_in;
  logic [3:0]   op_in;
  logic         inicio;
  logic         ocupado, listo, zf, ovf;
  logic [N-1:0] salida, hi, lo;

  alu_multiciclo_nbits #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .operacion_i(op_in),
    .inicio_i(inicio), .ocupado_o(ocupado), .listo_o(listo), .salida_o(salida),
    .hi_o(hi), .lo_o(lo), .zeroflag_o(zf), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [N-1:0] sal, ehi, elo;
    logic         ez, eo, chk_z;
    int           lat, acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [N-1:0] mhi = '0, mlo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every listo pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && listo) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_listo: got listo=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %-12s sal=%02h hi=%02h lo=%02h z=%0b v=%0b lat=%0d", e.name, salida, hi, lo, zf, ovf, cyc - e.acc + 1);
        chk({e.name, "_sal"}, 32'(salida), 32'(e.sal));
        chk({e.name, "_hi"},  32'(hi),     32'(e.ehi));
        chk({e.name, "_lo"},  32'(lo),     32'(e.elo));
        chk({e.name, "_ovf"}, 32'(ovf),    32'(e.eo));
        chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.chk_z) chk({e.name, "_zero"}, 32'(zf), 32'(e.ez));
      end
    end
  end

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no listo within 40 cycles, expected one", name);
      sb.delete();
    end
  endtask

  // is_long: expected HI/LO are given and become the new model; otherwise HI/LO must hold.
  task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] es, input bit is_long, input logic [N-1:0] eh, input logic [N-1:0] el,
                        input bit chk_z, input bit ez, input bit eo, input int lat, input int hold);
    exp_t e;
    @(negedge clk);
    op_in  = op;
    a_in   = a;
    b_in   = b;
    inicio = 1'b1;
    @(posedge clk); #1;
    e.name = name; e.sal = es; e.ez = ez; e.eo = eo; e.chk_z = chk_z; e.lat = lat; e.acc = cyc;
    if (is_long) begin
      e.ehi = eh; e.elo = el; mhi = eh; mlo = el;
    end else begin
      e.ehi = mhi; e.elo = mlo;
    end
    sb.push_back(e);
    chk({name, "_busy"}, 32'(ocupado), 32'd1);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    inicio = 1'b0;
    a_in   = 8'($urandom);
    b_in   = 8'($urandom);
    drain(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_sal"}, 32'(salida), 32'd0);
    chk({name, "_hi"},  32'(hi),     32'd0);
    chk({name, "_lo"},  32'(lo),     32'd0);
    chk({name, "_z"},   32'(zf),     32'd0);
    chk({name, "_v"},   32'(ovf),    32'd0);
    chk({name, "_busy"},32'(ocupado),32'd0);
    chk({name, "_rdy"}, 32'(listo),  32'd0);
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    //      name        op       a      b      sal   long hi     lo    chkz z  v  lat hold
    run_op("add_ovf",  4'b0010, 8'h7F, 8'h01, 8'h80, 0, 8'h00, 8'h00, 1, 0, 1, 1, 0);
    run_op("sub_zero", 4'b0110, 8'h05, 8'h05, 8'h00, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0);
    run_op("sub_ovf",  4'b0110, 8'h80, 8'h01, 8'h7F, 0, 8'h00, 8'h00, 1, 0, 1, 1, 0);
    run_op("and",      4'b0000, 8'hCC, 8'hAA, 8'h88, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("or",       4'b0001, 8'hC0, 8'h0A, 8'hCA, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("slt",      4'b0111, 8'hFE, 8'h01, 8'h01, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("sll",      4'b1001, 8'h81, 8'h09, 8'h02, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("srl",      4'b1010, 8'h80, 8'h03, 8'h10, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("sra",      4'b1011, 8'h80, 8'h0B, 8'hF0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("invalid",  4'b0011, 8'h05, 8'h05, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("multu_ff", 4'b1100, 8'hFF, 8'hFF, 8'h01, 1, 8'hFE, 8'h01, 1, 0, 0, 9, 0);
    run_op("add_hold", 4'b0010, 8'h10, 8'h20, 8'h30, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);
    run_op("multu_0",  4'b1100, 8'h00, 8'h37, 8'h00, 1, 8'h00, 8'h00, 1, 1, 0, 9, 0);
    run_op("mult_min", 4'b1101, 8'h80, 8'h80, 8'h00, 1, 8'h40, 8'h00, 1, 1, 0, 9, 0);
    run_op("mult_neg", 4'b1101, 8'hFD, 8'h05, 8'hF1, 1, 8'hFF, 8'hF1, 1, 0, 0, 9, 0);

    // Reset during the fourth CALC cycle of a MULTU discards the operation.
    @(negedge clk);
    op_in = 4'b1100; a_in = 8'h03; b_in = 8'h05; inicio = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    mhi = '0; mlo = '0;
    run_op("add_after",4'b0010, 8'h02, 8'h03, 8'h05, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0);

`ifdef ALU_MULTICICLO_DIV_EN
    run_op("divu",     4'b1110, 8'hC8, 8'h07, 8'h1C, 1, 8'h04, 8'h1C, 1, 0, 0, 9, 0);
    run_op("div_neg",  4'b1111, 8'hF9, 8'h02, 8'hFD, 1, 8'hFF, 8'hFD, 1, 0, 0, 9, 0);
    run_op("div_negb", 4'b1111, 8'h07, 8'hFE, 8'hFD, 1, 8'h01, 8'hFD, 1, 0, 0, 9, 0);
    run_op("divu_by0", 4'b1110, 8'h5A, 8'h00, 8'hFF, 1, 8'h5A, 8'hFF, 1, 0, 1, 9, 0);
    run_op("div_min",  4'b1111, 8'h80, 8'hFF, 8'h80, 1, 8'h00, 8'h80, 1, 0, 1, 9, 0);
`else
    run_op("mult_set", 4'b1101, 8'hFD, 8'h05, 8'hF1, 1, 8'hFF, 8'hF1, 1, 0, 0, 9, 0);
    run_op("divu_off", 4'b1110, 8'h10, 8'h02, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
    run_op("div_off",  4'b1111, 8'hF9, 8'h02, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
`endif

    // inicio held through all of CALC must still yield a single listo pulse.
    run_op("multu_held",4'b1100, 8'h03, 8'h05, 8'h0F, 1, 8'h00, 8'h0F, 1, 0, 0, 9, 8);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo_nbits.md
# alu_multiciclo_nbits

Parametrised N-bit registered ALU for the multicycle datapath. It extends the single-cycle ALU operation set with iterative multiply and divide, a HI/LO register pair, and signed-overflow and zero flags. Operations are launched with a start/busy/done handshake. It sits in the execute stage and stalls the control unit while `ocupado_o` is high.

## Interface
- `N`, 32, operand/result width; must be ≥ 4. Shift amount width is `$clog2(N)`.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `a_i`  in  N  operand A; dividend / multiplicand.
- `b_i`  in  N  operand B; divisor / multiplier / shift amount.
- `operacion_i`  in  4  operation code, sampled with `inicio_i`.
- `inicio_i`  in  1  start request.
- `ocupado_o`  out  1  high from the accepting edge until `listo_o` falls.
- `listo_o`  out  1  one-cycle pulse; results and flags are valid.
- `salida_o`  out  N  result; equals LO for mul/div.
- `hi_o`, `lo_o`  out  N each  HI/LO registers.
- `zeroflag_o`  out  1  `salida_o == 0`, registered with the result.
- `overflow_o`  out  1  signed ADD/SUB overflow, or DIV error.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed; result 1 or 0).
  - 1001 SLL, 1010 SRL, 1011 SRA (true arithmetic; sign fill).
  - 1100 MULTU, 1101 MULT, 1110 DIVU, 1111 DIV.
  - Any other code: result 0, flags 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: `inicio_i`=1 latches operands and code and sets `ocupado_o`.
    - Single-cycle codes go to DONE.
    - Mul/div codes go to CALC with the counter set to N.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter decrements; at counter 1 go to DONE.
  - DONE: `listo_o`=1; result registers update on entry; go to IDLE.
- Multiply:
  - Results: 2N-bit product; HI = upper half, LO = lower half.
  - MULT operates on magnitudes; the product is negated when the operand signs differ.
- Divide:
  - Results: LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = `a_i`, `overflow_o`=1.
  - DIV of most-negative / −1: LO = most-negative, HI = 0, `overflow_o`=1.
- Operand and register rules:
  - Shift amount = `b_i[$clog2(N)-1:0]`; upper bits are ignored.
  - HI/LO change only on mul/div completion. `salida_o` and flags hold until the next DONE.
  - `inicio_i` while `ocupado_o`=1 is ignored (not queued). Operand inputs may change freely after acceptance.
- Reset: asynchronous; returns to IDLE. `salida_o`, `hi_o`, `lo_o`, `zeroflag_o`, `overflow_o`, `ocupado_o`, `listo_o` all go to 0, including mid-CALC; the partial result is discarded.

## Timing
- Accepting edge k (IDLE, `inicio_i`=1).
- Single-cycle op: `listo_o` high during cycle k+1, with the result valid. Earliest next accept is edge k+2.
- Mul/div: CALC occupies cycles k+1..k+N; `listo_o` is high in cycle k+N+1. Latency is N+1 cycles.
- `ocupado_o`=1 from after edge k until the edge ending the DONE cycle.
- `listo_o` never asserts twice for one start. It is never high while the FSM is in IDLE.

## Configuration
- Macro: `ALU_MULTICICLO_DIV_EN`.
- Defined: DIVU/DIV are implemented as above, including the remainder datapath.
- Undefined:
  - The divider hardware is removed; codes 1110/1111 are treated as single-cycle invalid codes.
  - Result 0, HI/LO unchanged, `overflow_o`=1, `listo_o` at k+1.

## Test plan
- Test N=8 with macro defined unless noted.
- MULT a=0xFD (−3), b=0x05 → `listo_o` 9 cycles after accept; HI=0xFF, LO=0xF1, `salida_o`=0xF1, `zeroflag_o`=0.
- DIVU a=0xC8 (200), b=0x07 → LO=0x1C, HI=0x04. DIV a=0xF9 (−7), b=0x02 → LO=0xFD, HI=0xFF.
- DIVU b=0 → LO=0xFF, HI=a, `overflow_o`=1. DIV 0x80 / 0xFF → LO=0x80, HI=0x00, `overflow_o`=1.
- ADD 0x7F+0x01 → `salida_o`=0x80, `overflow_o`=1, `listo_o` at k+1. SUB 0x05−0x05 → 0x00, `zeroflag_o`=1. SRA 0x80, b=0x0B (amount 3) → 0xF0.
- Assert `rst_i` at CALC cycle 4 of MULTU → all outputs 0 immediately; a new ADD starts cleanly after release. `inicio_i` held high during CALC → exactly one `listo_o`.
- Macro undefined: DIVU 0x10/0x02 → `listo_o` at k+1, `salida_o`=0, `overflow_o`=1, HI/LO unchanged.
